// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter slice.
//   WB_N    : default register-file data width
//   WB_R    : default register-file address width
//   REG0    : index of the hard-wired zero register; writes to it are dropped
//   wb_req_t: one register-file write request (enable, address, data)
package wb_pkg;
    localparam int WB_N = 16;
    localparam int WB_R = 3;
    localparam int REG0 = 0;

    typedef struct packed {
        logic            we;
        logic [WB_R-1:0] wa;
        logic [WB_N-1:0] wd;
    } wb_req_t;
endpackage

// File: rtl/wb_arbiter_scoreboard.sv
// Scoreboard of registers with an outstanding long-latency write.
//   clk, rst_n         : clock, synchronous active-low reset
//   set_en, set_idx    : mark a register pending (long op issued)
//   clr_en, clr_idx    : release a register (held result written or dropped)
//   chk_valid, chk_ra1,
//   chk_ra2, chk_rd    : three-port hazard lookup from decode
//   pending            : registered scoreboard bits, bit 0 always 0
//   hazard             : combinational, any checked register is pending
module wb_arbiter_scoreboard
    import wb_pkg::*;
#(
    parameter int R = WB_R
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  logic [R-1:0]    set_idx,
    input  logic            clr_en,
    input  logic [R-1:0]    clr_idx,
    input  logic            chk_valid,
    input  logic [R-1:0]    chk_ra1,
    input  logic [R-1:0]    chk_ra2,
    input  logic [R-1:0]    chk_rd,
    output logic [2**R-1:0] pending,
    output logic            hazard
);
    logic [2**R-1:0] pending_d;
    logic [2**R-1:0] pending_q;

    // Clear is applied before set, so a re-issue to the register that is
    // draining in the same cycle keeps it pending for the new long op.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) pending_d[clr_idx] = 1'b0;
        if (set_en) pending_d[set_idx] = 1'b1;
        pending_d[REG0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    assign pending = pending_q;
    assign hazard  = chk_valid &&
                     (pending_q[chk_ra1] || pending_q[chk_ra2] || pending_q[chk_rd]);
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges MEM/WB results and long-unit results onto the
// register file's single write port, pipeline first. Long results wait in a
// one-entry hold buffer; a starvation counter requests a pipeline bubble when
// a held result has been blocked too long.
//   pipe_we/wa/wd      : MEM/WB write, always accepted
//   lu_valid/wa/wd     : long-unit result, lu_ready is the accept handshake
//   iss_long, iss_rd   : decode issues a long op (marks iss_rd pending)
//   chk_*              : decode hazard lookup, hazard is combinational
//   we3/wa3/wd3        : registered register-file write port
//   pending            : registered scoreboard bits
//   stall_req          : registered bubble request to the pipeline
//   wb_err             : sticky, a pipeline write hit a pending register
//
// Handshake: the long unit holds lu_valid/lu_wa/lu_wd stable until it sees
// lu_ready=1; a transfer happens on every rising edge where lu_valid and
// lu_ready are both 1, and lu_ready never depends on lu_valid.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int N      = WB_N,
    parameter int R      = WB_R,
    parameter int STARVE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_we,
    input  logic [R-1:0]    pipe_wa,
    input  logic [N-1:0]    pipe_wd,
    input  logic            lu_valid,
    input  logic [R-1:0]    lu_wa,
    input  logic [N-1:0]    lu_wd,
    output logic            lu_ready,
    input  logic            iss_long,
    input  logic [R-1:0]    iss_rd,
    input  logic            chk_valid,
    input  logic [R-1:0]    chk_ra1,
    input  logic [R-1:0]    chk_ra2,
    input  logic [R-1:0]    chk_rd,
    output logic            hazard,
    output logic            stall_req,
    output logic            we3,
    output logic [R-1:0]    wa3,
    output logic [N-1:0]    wd3,
    output logic [2**R-1:0] pending,
    output logic            wb_err
);
    localparam int CW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

    logic            hold_valid_d, hold_valid_q;
    logic [R-1:0]    hold_wa_d,    hold_wa_q;
    logic [N-1:0]    hold_wd_d,    hold_wd_q;
    logic            we3_d,        we3_q;
    logic [R-1:0]    wa3_d,        wa3_q;
    logic [N-1:0]    wd3_d,        wd3_q;
    logic [CW-1:0]   cnt_d,        cnt_q;
    logic            stall_d,      stall_q;
    logic            wb_err_d,     wb_err_q;

    logic pe;
    logic lu_fire;
    logic drain;

    assign pe       = pipe_we && (pipe_wa != R'(REG0));
    assign lu_ready = !hold_valid_q || !pe;
    assign lu_fire  = lu_valid && lu_ready;
    // The held entry leaves whenever the pipeline is not using the port,
    // either as a real write or, for r0, silently dropped.
    assign drain    = hold_valid_q && !pe;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_wa_d    = hold_wa_q;
        hold_wd_d    = hold_wd_q;
        if (drain) hold_valid_d = 1'b0;
        // Load after drain so a same-cycle drain+load keeps the entry full.
        if (lu_fire) begin
            hold_valid_d = 1'b1;
            hold_wa_d    = lu_wa;
            hold_wd_d    = lu_wd;
        end
    end

    always_comb begin
        we3_d = 1'b0;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (pe) begin
            we3_d = 1'b1;
            wa3_d = pipe_wa;
            wd3_d = pipe_wd;
        end else if (hold_valid_q && (hold_wa_q != R'(REG0))) begin
            we3_d = 1'b1;
            wa3_d = hold_wa_q;
            wd3_d = hold_wd_q;
        end
    end

    // Counts cycles the held result lost the port; saturates so stall_req
    // stays up until the bubble arrives and the entry drains.
    always_comb begin
        cnt_d = cnt_q;
        if (drain)
            cnt_d = '0;
        else if (hold_valid_q && pe && (cnt_q != CW'(STARVE)))
            cnt_d = cnt_q + 1'b1;
        stall_d = (cnt_d == CW'(STARVE));
    end

    always_comb begin
        wb_err_d = wb_err_q || (pe && pending[pipe_wa]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_wa_q    <= '0;
            hold_wd_q    <= '0;
            we3_q        <= 1'b0;
            wa3_q        <= '0;
            wd3_q        <= '0;
            cnt_q        <= '0;
            stall_q      <= 1'b0;
            wb_err_q     <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_wa_q    <= hold_wa_d;
            hold_wd_q    <= hold_wd_d;
            we3_q        <= we3_d;
            wa3_q        <= wa3_d;
            wd3_q        <= wd3_d;
            cnt_q        <= cnt_d;
            stall_q      <= stall_d;
            wb_err_q     <= wb_err_d;
        end
    end

    wb_arbiter_scoreboard #(.R(R)) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (iss_long && (iss_rd != R'(REG0))),
        .set_idx   (iss_rd),
        .clr_en    (drain),
        .clr_idx   (hold_wa_q),
        .chk_valid (chk_valid),
        .chk_ra1   (chk_ra1),
        .chk_ra2   (chk_ra2),
        .chk_rd    (chk_rd),
        .pending   (pending),
        .hazard    (hazard)
    );

    assign we3       = we3_q;
    assign wa3       = wa3_q;
    assign wd3       = wd3_q;
    assign stall_req = stall_q;
    assign wb_err    = wb_err_q;
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int N = 16;
    localparam int R = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pipe_we;
    logic [R-1:0] pipe_wa;
    logic [N-1:0] pipe_wd;
    logic         lu_valid;
    logic [R-1:0] lu_wa;
    logic [N-1:0] lu_wd;
    logic         lu_ready;
    logic         iss_long;
    logic [R-1:0] iss_rd;
    logic         chk_valid;
    logic [R-1:0] chk_ra1, chk_ra2, chk_rd;
    logic         hazard;
    logic         stall_req;
    logic         we3;
    logic [R-1:0] wa3;
    logic [N-1:0] wd3;
    logic [7:0]   pending;
    logic         wb_err;

    int n_checks = 0;
    int n_pass   = 0;

    // clock / reset
    always #5 clk = ~clk;

    wb_arbiter #(.N(N), .R(R), .STARVE(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .lu_valid(lu_valid), .lu_wa(lu_wa), .lu_wd(lu_wd), .lu_ready(lu_ready),
        .iss_long(iss_long), .iss_rd(iss_rd),
        .chk_valid(chk_valid), .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .chk_rd(chk_rd),
        .hazard(hazard), .stall_req(stall_req),
        .we3(we3), .wa3(wa3), .wd3(wd3), .pending(pending), .wb_err(wb_err)
    );

    typedef struct {
        logic         rst_n;
        wb_req_t      pipe;
        wb_req_t      lu;
        logic         iss_long;
        logic [R-1:0] iss_rd;
        logic         chk_valid;
        logic [R-1:0] ra1, ra2, rd;
        logic         exp_rdy;
        logic         exp_haz;
        wb_req_t      exp_wr;
        logic [7:0]   exp_pend;
        logic         exp_stall;
        logic         exp_err;
    } vec_t;

    vec_t vecs[$];

    // scoreboard: expected values for the current step
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic add(input logic rst, input logic pwe, input int pwa, input int pwd,
                       input logic luv, input int luwa, input int luwd,
                       input logic il, input int ird,
                       input logic cv, input int c1, input int c2, input int cd,
                       input logic rdy, input logic haz,
                       input logic ewe, input int ewa, input int ewd,
                       input int epend, input logic estall, input logic eerr);
        vec_t v;
        v.rst_n = rst;
        v.pipe  = '{we: pwe, wa: R'(pwa), wd: N'(pwd)};
        v.lu    = '{we: luv, wa: R'(luwa), wd: N'(luwd)};
        v.iss_long = il;  v.iss_rd = R'(ird);
        v.chk_valid = cv; v.ra1 = R'(c1); v.ra2 = R'(c2); v.rd = R'(cd);
        v.exp_rdy = rdy;  v.exp_haz = haz;
        v.exp_wr  = '{we: ewe, wa: R'(ewa), wd: N'(ewd)};
        v.exp_pend = 8'(epend); v.exp_stall = estall; v.exp_err = eerr;
        vecs.push_back(v);
    endtask

    // driver
    task automatic drive(input vec_t v);
        rst_n     = v.rst_n;
        pipe_we   = v.pipe.we;  pipe_wa = v.pipe.wa;  pipe_wd = v.pipe.wd;
        lu_valid  = v.lu.we;    lu_wa   = v.lu.wa;    lu_wd   = v.lu.wd;
        iss_long  = v.iss_long; iss_rd  = v.iss_rd;
        chk_valid = v.chk_valid;
        chk_ra1   = v.ra1; chk_ra2 = v.ra2; chk_rd = v.rd;
    endtask

    task automatic drive_idle();
        rst_n = 1'b1; pipe_we = 1'b0; pipe_wa = '0; pipe_wd = '0;
        lu_valid = 1'b0; lu_wa = '0; lu_wd = '0;
        iss_long = 1'b0; iss_rd = '0;
        chk_valid = 1'b0; chk_ra1 = '0; chk_ra2 = '0; chk_rd = '0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        @(negedge clk);
        drive(v);
        #1;
        tag = $sformatf("v%0d", idx);
        check({tag, ".lu_ready"}, 32'(lu_ready), 32'(v.exp_rdy));
        check({tag, ".hazard"},   32'(hazard),   32'(v.exp_haz));
        exp_q.push_back(32'(v.exp_wr.we));
        exp_q.push_back(32'(v.exp_wr.wa));
        exp_q.push_back(32'(v.exp_wr.wd));
        exp_q.push_back(32'(v.exp_pend));
        exp_q.push_back(32'(v.exp_stall));
        exp_q.push_back(32'(v.exp_err));
        @(posedge clk);
        #1;
        check({tag, ".we3"},       32'(we3),       exp_q.pop_front());
        check({tag, ".wa3"},       32'(wa3),       exp_q.pop_front());
        check({tag, ".wd3"},       32'(wd3),       exp_q.pop_front());
        check({tag, ".pending"},   32'(pending),   exp_q.pop_front());
        check({tag, ".stall_req"}, 32'(stall_req), exp_q.pop_front());
        check({tag, ".wb_err"},    32'(wb_err),    exp_q.pop_front());
    endtask

    initial begin
        int cycles;

        //   rst pwe pwa pwd     luv lwa lwd     il ird cv c1 c2 cd  rdy haz we wa wd      pend stl err
        // reset (second cycle) with a long result offered
        add(0, 0, 0, 0,       1, 7, 'h7777, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,      'h00, 0, 0);
        // pipeline pass-through, then r0 write dropped
        add(1, 1, 3, 'h1234,  0, 0, 0,      0, 0, 0, 0, 0, 0, 1, 0, 1, 3, 'h1234, 'h00, 0, 0);
        add(1, 1, 0, 'h5555,  0, 0, 0,      0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 'h1234, 'h00, 0, 0);
        // scoreboard round trip on r5
        add(1, 0, 0, 0,       0, 0, 0,      1, 5, 0, 0, 0, 0, 1, 0, 0, 3, 'h1234, 'h20, 0, 0);
        add(1, 0, 0, 0,       0, 0, 0,      0, 0, 1, 5, 0, 0, 1, 1, 0, 3, 'h1234, 'h20, 0, 0);
        add(1, 0, 0, 0,       1, 5, 'hBEEF, 0, 0, 1, 5, 0, 0, 1, 1, 0, 3, 'h1234, 'h20, 0, 0);
        add(1, 0, 0, 0,       0, 0, 0,      0, 0, 1, 5, 0, 0, 1, 1, 1, 5, 'hBEEF, 'h00, 0, 0);
        add(1, 0, 0, 0,       0, 0, 0,      0, 0, 1, 5, 0, 0, 1, 0, 0, 5, 'hBEEF, 'h00, 0, 0);
        // collision: r2 from pipe first, r6 from hold next
        add(1, 1, 2, 'h0001,  1, 6, 'h0006, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 'h0001, 'h00, 0, 0);
        add(1, 0, 0, 0,       0, 0, 0,      0, 0, 0, 0, 0, 0, 1, 0, 1, 6, 'h0006, 'h00, 0, 0);
        // load r7, then starve it for 5 cycles while r3 is refused
        add(1, 0, 0, 0,       1, 7, 'h0777, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6, 'h0006, 'h00, 0, 0);
        add(1, 1, 1, 'h0011,  1, 3, 'h0333, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h0011, 'h00, 0, 0);
        add(1, 1, 1, 'h0012,  1, 3, 'h0333, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h0012, 'h00, 0, 0);
        add(1, 1, 1, 'h0013,  1, 3, 'h0333, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h0013, 'h00, 0, 0);
        add(1, 1, 1, 'h0014,  1, 3, 'h0333, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h0014, 'h00, 1, 0);
        add(1, 1, 1, 'h0015,  1, 3, 'h0333, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h0015, 'h00, 1, 0);
        add(1, 0, 0, 0,       0, 0, 0,      0, 0, 0, 0, 0, 0, 1, 0, 1, 7, 'h0777, 'h00, 0, 0);
        add(1, 0, 0, 0,       0, 0, 0,      0, 0, 0, 0, 0, 0, 1, 0, 0, 7, 'h0777, 'h00, 0, 0);
        // set wins over clear on r4
        add(1, 0, 0, 0,       0, 0, 0,      1, 4, 0, 0, 0, 0, 1, 0, 0, 7, 'h0777, 'h10, 0, 0);
        add(1, 0, 0, 0,       1, 4, 'h4444, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7, 'h0777, 'h10, 0, 0);
        add(1, 0, 0, 0,       0, 0, 0,      1, 4, 0, 4, 0, 0, 1, 0, 1, 4, 'h4444, 'h10, 0, 0);
        // pipeline write to pending r4 -> sticky wb_err; iss to r0 ignored
        add(1, 1, 4, 'h0404,  0, 0, 0,      0, 0, 1, 0, 0, 4, 1, 1, 1, 4, 'h0404, 'h10, 0, 1);
        add(1, 0, 0, 0,       0, 0, 0,      1, 0, 0, 0, 0, 0, 1, 0, 0, 4, 'h0404, 'h10, 0, 1);
        // long result to r0: consumed and dropped
        add(1, 0, 0, 0,       1, 0, 'hDEAD, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4, 'h0404, 'h10, 0, 1);
        add(1, 0, 0, 0,       0, 0, 0,      0, 0, 0, 0, 0, 0, 1, 0, 0, 4, 'h0404, 'h10, 0, 1);
        add(1, 1, 2, 'h2222,  0, 0, 0,      0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 'h2222, 'h10, 0, 1);
        // reset mid-operation discards hold and pending
        add(1, 0, 0, 0,       1, 4, 'h4000, 1, 3, 0, 0, 0, 0, 1, 0, 0, 2, 'h2222, 'h18, 0, 1);
        add(0, 1, 1, 'h0101,  0, 0, 0,      0, 0, 1, 0, 3, 0, 0, 1, 0, 0, 'h0000, 'h00, 0, 0);
        add(1, 0, 0, 0,       0, 0, 0,      0, 0, 1, 0, 3, 0, 1, 0, 0, 0, 'h0000, 'h00, 0, 0);

        // first reset cycle (outputs undefined before it)
        drive_idle();
        rst_n = 1'b0;
        lu_valid = 1'b1;
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++)
            run_vec(i, vecs[i]);

        // hand-written: starvation latency measured with a bounded wait
        @(negedge clk);
        drive_idle();
        lu_valid = 1'b1; lu_wa = 3'd5; lu_wd = 16'h5A5A;
        @(negedge clk);
        drive_idle();
        pipe_we = 1'b1; pipe_wa = 3'd2; pipe_wd = 16'h0F0F;
        cycles = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            cycles = i;
            if (stall_req) break;
        end
        check("starve.cycles_to_stall", 32'(cycles), 32'd4);
        check("starve.stall_req", 32'(stall_req), 32'd1);
        @(negedge clk);
        pipe_we = 1'b0;
        @(posedge clk);
        #1;
        check("starve.drain_we3", 32'(we3), 32'd1);
        check("starve.drain_wa3", 32'(wa3), 32'd5);
        check("starve.drain_wd3", 32'(wd3), 32'h5A5A);
        check("starve.stall_clear", 32'(stall_req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
